// File: rtl/ps2_key_pkg.sv
// Shared scan-code constants, entry-state encoding and key classifiers.
package ps2_key_pkg;

  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23, SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33, SC_I = 8'h43, SC_J = 8'h3B;

  localparam logic [7:0] SC_0 = 8'h45, SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E, SC_6 = 8'h36, SC_7 = 8'h3D, SC_8 = 8'h3E, SC_9 = 8'h46;

  // Returned by the classifiers when the code is not of that class.
  localparam logic [3:0] IDX_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HAVE_L = 2'd1,
    ST_HAVE_N = 2'd2,
    ST_OFFER  = 2'd3
  } seq_state_e;

  function automatic logic [3:0] is_letter(input logic [7:0] c);
    case (c)
      SC_A:    return 4'd0;
      SC_B:    return 4'd1;
      SC_C:    return 4'd2;
      SC_D:    return 4'd3;
      SC_E:    return 4'd4;
      SC_F:    return 4'd5;
      SC_G:    return 4'd6;
      SC_H:    return 4'd7;
      SC_I:    return 4'd8;
      SC_J:    return 4'd9;
      default: return IDX_NONE;
    endcase
  endfunction

  function automatic logic [3:0] is_digit(input logic [7:0] c);
    case (c)
      SC_0:    return 4'd0;
      SC_1:    return 4'd1;
      SC_2:    return 4'd2;
      SC_3:    return 4'd3;
      SC_4:    return 4'd4;
      SC_5:    return 4'd5;
      SC_6:    return 4'd6;
      SC_7:    return 4'd7;
      SC_8:    return 4'd8;
      SC_9:    return 4'd9;
      default: return IDX_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_sequencer_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge sampling, 11-bit
// frame assembly with start/stop/odd-parity check and a partial-frame watchdog.
module ps2_rx_frame #(
  parameter int TIMEOUT_CYCLES = 27000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] kclk_sync_q, kdat_sync_q;
  logic                   kclk_prev_q;
  logic                   kclk_s, kdat_s, fall;
  logic [10:0]            sr_q;
  logic [3:0]             cnt_q;
  logic [TW-1:0]          tmo_q;
  logic                   done_q;
  logic                   rx_valid_q, rx_err_q;
  logic [7:0]             rx_byte_q;
  logic                   frame_ok;

  assign kclk_s = kclk_sync_q[SYNC_STAGES-1];
  assign kdat_s = kdat_sync_q[SYNC_STAGES-1];
  assign fall   = kclk_prev_q & ~kclk_s;

  // sr_q[0]=start, sr_q[8:1]=D0..D7, sr_q[9]=parity, sr_q[10]=stop
  assign frame_ok = ~sr_q[0] & sr_q[10] & (^sr_q[9:1]);

  // Pin synchronisers; idle line level is high so reset to 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kclk_sync_q <= '1;
      kdat_sync_q <= '1;
      kclk_prev_q <= 1'b1;
    end else begin
      kclk_sync_q <= {kclk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      kdat_sync_q <= {kdat_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      kclk_prev_q <= kclk_s;
    end
  end

  // Bit shifter, frame check one cycle after the last bit, and watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (fall) begin
        sr_q  <= {kdat_s, sr_q[10:1]};
        tmo_q <= '0;
        if (cnt_q == 4'd10) begin
          cnt_q  <= '0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end else if (cnt_q != 4'd0) begin
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          cnt_q    <= '0;
          tmo_q    <= '0;
          rx_err_q <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
      if (done_q) begin
        if (frame_ok) begin
          rx_valid_q <= 1'b1;
          rx_byte_q  <= sr_q[8:1];
        end else begin
          rx_err_q <= 1'b1;
        end
      end
    end
  end

  assign rx_valid_o = rx_valid_q;
  assign rx_byte_o  = rx_byte_q;
  assign rx_err_o   = rx_err_q;

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 keyboard to letter+number entry: receiver, prefix/repeat filtering
// decoder and the entry state machine with a valid/ready offer.
module ps2_key_sequencer
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 27000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock27,
  input  logic       resetn,
  input  logic       keyboardClock,
  input  logic       keyboardData,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       frame_error,
  output logic       entry_valid,
  input  logic       entry_ready,
  output logic [3:0] entry_letter,
  output logic [3:0] entry_number,
  output logic [1:0] seq_state
);

  logic       rx_valid, rx_err;
  logic [7:0] rx_byte;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk_i     (clock27),
    .rst_ni    (resetn),
    .ps2_clk_i (keyboardClock),
    .ps2_data_i(keyboardData),
    .rx_valid_o(rx_valid),
    .rx_byte_o (rx_byte),
    .rx_err_o  (rx_err)
  );

  logic       brk_q, ext_q;
  logic [7:0] held_q;
  logic       key_valid_q;
  logic [7:0] key_code_q;

  // Decoder: strip F0/E0 prefixed codes, suppress typematic repeats of the held key.
  always_ff @(posedge clock27 or negedge resetn) begin
    if (!resetn) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      held_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      key_valid_q <= 1'b0;
      if (rx_err) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == SC_F0) begin
          brk_q <= 1'b1;
        end else if (rx_byte == SC_E0) begin
          ext_q <= 1'b1;
        end else if (brk_q || ext_q) begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if (brk_q && !ext_q && rx_byte == held_q) held_q <= '0;
        end else if (rx_byte != held_q) begin
          held_q      <= rx_byte;
          key_valid_q <= 1'b1;
          key_code_q  <= rx_byte;
        end
      end
    end
  end

  seq_state_e state_q, state_d;
  logic [3:0] letter_q, letter_d, number_q, number_d;
  logic [3:0] lidx, didx;

  assign lidx = is_letter(key_code_q);
  assign didx = is_digit(key_code_q);

  // Entry FSM state and stored letter/number.
  always_ff @(posedge clock27 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      letter_q <= '0;
      number_q <= '0;
    end else begin
      state_q  <= state_d;
      letter_q <= letter_d;
      number_q <= number_d;
    end
  end

  // Entry FSM next state; key events are ignored while an entry is on offer.
  always_comb begin
    state_d  = state_q;
    letter_d = letter_q;
    number_d = number_q;
    case (state_q)
      ST_IDLE: begin
        if (key_valid_q && lidx != IDX_NONE) begin
          letter_d = lidx;
          state_d  = ST_HAVE_L;
        end
      end
      ST_HAVE_L: begin
        if (key_valid_q) begin
          if (didx != IDX_NONE) begin
            number_d = didx;
            state_d  = ST_HAVE_N;
          end else if (lidx != IDX_NONE) begin
            letter_d = lidx;
          end else if (key_code_q == SC_BKSP || key_code_q == SC_ESC) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HAVE_N: begin
        if (key_valid_q) begin
          if (key_code_q == SC_ENTER) begin
            state_d = ST_OFFER;
          end else if (didx != IDX_NONE) begin
            number_d = didx;
          end else if (lidx != IDX_NONE) begin
            letter_d = lidx;
            state_d  = ST_HAVE_L;
          end else if (key_code_q == SC_BKSP) begin
            state_d = ST_HAVE_L;
          end else if (key_code_q == SC_ESC) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OFFER: begin
        if (entry_ready) state_d = ST_IDLE;
      end
    endcase
  end

  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign frame_error  = rx_err;
  assign entry_valid  = (state_q == ST_OFFER);
  assign entry_letter = letter_q;
  assign entry_number = number_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench: PS/2 frames driven bit by bit, outputs checked against a byte-level
// reference model of the key decoder and entry rules.
module tb_ps2_key_sequencer;

  localparam int TO   = 27000;
  localparam int HALF = 8;

  logic       clock27 = 1'b0;
  logic       resetn, keyboardClock, keyboardData, entry_ready;
  logic       key_valid, frame_error, entry_valid;
  logic [7:0] key_code;
  logic [3:0] entry_letter, entry_number;
  logic [1:0] seq_state;

  always #5 clock27 = ~clock27;

  ps2_key_sequencer dut (
    .clock27      (clock27),
    .resetn       (resetn),
    .keyboardClock(keyboardClock),
    .keyboardData (keyboardData),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .frame_error  (frame_error),
    .entry_valid  (entry_valid),
    .entry_ready  (entry_ready),
    .entry_letter (entry_letter),
    .entry_number (entry_number),
    .seq_state    (seq_state)
  );

  int n_cmp = 0, n_bad = 0;

  // Observed events, sampled once per cycle away from the active edge.
  logic [7:0] got_keys[$];
  logic [7:0] got_offers[$];
  int cyc = 0, err_cnt = 0, err_cyc = 0, ev_cycles = 0;

  always @(negedge clock27) begin
    #1;
    cyc++;
    if (key_valid) got_keys.push_back(key_code);
    if (frame_error) begin err_cnt++; err_cyc = cyc; end
    if (entry_valid) begin
      ev_cycles++;
      if (entry_ready) got_offers.push_back({entry_letter, entry_number});
    end
  end

  // Reference model state.
  logic [7:0] exp_keys[$];
  logic [7:0] exp_offers[$];
  int         exp_err = 0;
  logic [7:0] m_held = 8'h00;
  bit         m_brk = 0, m_ext = 0;
  int         m_state = 0;
  logic [3:0] m_let = 0, m_num = 0;
  logic [7:0] LET[10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
  logic [7:0] DIG[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  int last_fall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 8'h00; m_brk = 0; m_ext = 0; m_state = 0; m_let = 0; m_num = 0;
  endtask

  // Entry rules applied to one accepted make code.
  task automatic model_key(input logic [7:0] k);
    int li, di;
    li = -1; di = -1;
    for (int i = 0; i < 10; i++) begin
      if (LET[i] == k) li = i;
      if (DIG[i] == k) di = i;
    end
    case (m_state)
      0: if (li >= 0) begin m_let = 4'(li); m_state = 1; end
      1: begin
        if (di >= 0) begin m_num = 4'(di); m_state = 2; end
        else if (li >= 0) m_let = 4'(li);
        else if (k == 8'h66 || k == 8'h76) m_state = 0;
      end
      2: begin
        if (k == 8'h5A) begin
          if (entry_ready) begin exp_offers.push_back({m_let, m_num}); m_state = 0; end
          else m_state = 3;
        end
        else if (di >= 0) m_num = 4'(di);
        else if (li >= 0) begin m_let = 4'(li); m_state = 1; end
        else if (k == 8'h66) m_state = 1;
        else if (k == 8'h76) m_state = 0;
      end
      default: ;
    endcase
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_brk || m_ext) begin
      if (m_brk && !m_ext && b == m_held) m_held = 8'h00;
      m_brk = 0; m_ext = 0;
    end else if (b != m_held) begin
      m_held = b;
      exp_keys.push_back(b);
      model_key(b);
    end
  endtask

  task automatic verify(input string tag);
    chk({tag, ".nkeys"}, got_keys.size(), exp_keys.size());
    while (got_keys.size() > 0 && exp_keys.size() > 0)
      chk({tag, ".key_code"}, got_keys.pop_front(), exp_keys.pop_front());
    got_keys.delete(); exp_keys.delete();
    chk({tag, ".noffers"}, got_offers.size(), exp_offers.size());
    while (got_offers.size() > 0 && exp_offers.size() > 0)
      chk({tag, ".offer"}, got_offers.pop_front(), exp_offers.pop_front());
    got_offers.delete(); exp_offers.delete();
    chk({tag, ".seq_state"}, seq_state, m_state);
    chk({tag, ".frame_errors"}, err_cnt, exp_err);
    chk({tag, ".letter"}, entry_letter, m_let);
    chk({tag, ".number"}, entry_number, m_num);
  endtask

  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock27); keyboardData = f[i];
      repeat (HALF) @(negedge clock27);
      keyboardClock = 1'b0; last_fall = cyc;
      repeat (HALF) @(negedge clock27);
      keyboardClock = 1'b1;
    end
  endtask

  task automatic send(input string tag, input logic [7:0] b, input bit bad = 0);
    logic [10:0] f;
    f = {1'b1, (bad ? ^b : ~^b), b, 1'b0};
    ps2_bits(f, 11);
    keyboardData = 1'b1;
    repeat (30) @(negedge clock27);
    if (bad) begin exp_err++; m_brk = 0; m_ext = 0; end
    else model_byte(b);
    verify(tag);
  endtask

  initial begin
    int e0, hi, r, k;
    logic [7:0] b;
    resetn = 1'b0; keyboardClock = 1'b1; keyboardData = 1'b1; entry_ready = 1'b1;
    repeat (3) @(negedge clock27);
    chk("rst.key_valid", key_valid, 0);
    chk("rst.key_code", key_code, 0);
    chk("rst.frame_error", frame_error, 0);
    chk("rst.entry_valid", entry_valid, 0);
    chk("rst.seq_state", seq_state, 0);
    chk("rst.letter", entry_letter, 0);
    chk("rst.number", entry_number, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clock27);

    // Basic entry C7 with break codes in between.
    send("c7.21", 8'h21); send("c7.f0", 8'hF0); send("c7.21b", 8'h21);
    send("c7.3d", 8'h3D); send("c7.f0b", 8'hF0); send("c7.3db", 8'h3D);
    e0 = ev_cycles;
    send("c7.enter", 8'h5A);
    chk("c7.ev_cycles", ev_cycles - e0, 1);

    // Parity error, then a good frame.
    send("par.bad", 8'h1C, 1);
    send("par.good", 8'h1C);

    // Typematic repeat suppression.
    send("rep.32a", 8'h32); send("rep.32b", 8'h32); send("rep.32c", 8'h32);
    send("rep.f0", 8'hF0); send("rep.32brk", 8'h32); send("rep.32new", 8'h32);

    // Extended prefix consumes the next code.
    send("ext.e0", 8'hE0); send("ext.1c", 8'h1C); send("ext.1c2", 8'h1C);

    // Hold offer with entry_ready low.
    send("hold.f0", 8'hF0); send("hold.1cb", 8'h1C); send("hold.a", 8'h1C);
    send("hold.5", 8'h2E); send("hold.bksp", 8'h66); send("hold.9", 8'h46);
    entry_ready = 1'b0;
    send("hold.enter", 8'h5A);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock27);
      if (entry_valid) hi++;
    end
    chk("hold.valid_cycles", hi, 10);
    send("hold.e_ignored", 8'h24);
    @(negedge clock27); entry_ready = 1'b1;
    @(negedge clock27);
    exp_offers.push_back({m_let, m_num}); m_state = 0;
    repeat (3) @(negedge clock27);
    chk("hold.released", entry_valid, 0);
    verify("hold.done");

    // Randomized key traffic.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 9);
      case (r)
        0, 1, 2: b = LET[k];
        3, 4, 5: b = DIG[k];
        6:       b = 8'h5A;
        7:       b = (k < 5) ? 8'h66 : 8'h76;
        8:       b = (k < 6) ? 8'hF0 : 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send("rnd", b, ($urandom_range(0, 11) == 0));
    end

    // Reset in the middle of a frame.
    ps2_bits(11'b11000010100, 5);
    keyboardData = 1'b1;
    resetn = 1'b0;
    repeat (3) @(negedge clock27);
    resetn = 1'b1;
    model_reset();
    repeat (5) @(negedge clock27);
    chk("rstmid.seq_state", seq_state, 0);
    chk("rstmid.key_code", key_code, 0);
    send("rstmid.21", 8'h21);

    // Watchdog on a partial frame.
    ps2_bits(11'b10101010100, 6);
    keyboardData = 1'b1;
    repeat (30000) @(negedge clock27);
    exp_err++; m_brk = 0; m_ext = 0;
    chk("tmo.latency_ok", ((err_cyc - last_fall) >= TO) && ((err_cyc - last_fall) <= TO + 8), 1);
    verify("tmo");
    send("tmo.45", 8'h45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
